// File: rtl/rr_pkg.sv
// rr_pkg: shared channel state, widths and grant helpers
// for the rr_req_master requester.
package rr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_BURST
   } chan_st_e;

   localparam int RR_N = 4;
   localparam int IDW  = $clog2(RR_N);

   function automatic logic onehot0(input logic [15:0] v);
      return (v & (v - 16'd1)) == 16'd0;
   endfunction

endpackage

// File: rtl/rr_req_chan.sv
// rr_req_chan: one client channel's request FSM and burst
// beat counter.
module rr_req_chan
   import rr_pkg::*;
#(
   parameter int LENW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_valid,
   input  logic            i_accept,
   input  logic            i_beat,
   input  logic [LENW-1:0] i_len,
   output logic            o_req,
   output logic            o_burst,
   output logic            o_last
);

   chan_st_e        r_st;
   chan_st_e        w_st_nx;
   logic [LENW-1:0] r_cnt;
   logic [LENW-1:0] w_cnt_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_st  <= ST_IDLE;
         r_cnt <= '0;
      end else begin
         r_st  <= w_st_nx;
         r_cnt <= w_cnt_nx;
      end
   end

   always_comb begin
      w_st_nx  = r_st;
      w_cnt_nx = r_cnt;
      case (r_st)
         ST_IDLE: begin
            if (i_valid) w_st_nx = ST_REQ;
         end
         ST_REQ: begin
            if (i_accept) begin
               w_st_nx  = ST_BURST;
               w_cnt_nx = i_len;
            end
         end
         ST_BURST: begin
            if (i_beat) begin
               if (r_cnt == '0) w_st_nx = ST_IDLE;
               else w_cnt_nx = r_cnt - LENW'(1);
            end
         end
         default: w_st_nx = ST_IDLE;
      endcase
   end

   // Request stays high through the burst as the bus lock.
   assign o_req   = (r_st != ST_IDLE);
   assign o_burst = (r_st == ST_BURST);
   assign o_last  = (r_cnt == '0);

endmodule

// File: rtl/rr_req_master.sv
// rr_req_master: N-client burst requester for the round-robin
// arbiter. Define GNT_CHECK_EN to add the sticky gnt_err output.
module rr_req_master
   import rr_pkg::*;
#(
   parameter int N    = RR_N,
   parameter int W    = 32,
   parameter int LENW = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         cli_valid,
   input  logic [N*W-1:0]       cli_data,
   input  logic [N*LENW-1:0]    cli_len,
   output logic [N-1:0]         cli_ready,
   output logic [N-1:0]         arb_req,
   input  logic [N-1:0]         arb_gnt,
   output logic                 bus_valid,
   output logic [W-1:0]         bus_data,
   output logic [$clog2(N)-1:0] bus_id,
   output logic                 bus_last,
   input  logic                 bus_ready,
   output logic                 busy
`ifdef GNT_CHECK_EN
   ,
   output logic                 gnt_err
`endif
);

   localparam int IW = $clog2(N);

   logic [N-1:0]  w_req;
   logic [N-1:0]  w_burst;
   logic [N-1:0]  w_last;
   logic [N-1:0]  w_accept;
   logic [N-1:0]  w_beat;
   logic [IW-1:0] w_gnt_idx;
   logic          w_gnt_any;
   logic          w_busy;
   logic [IW-1:0] r_owner;

   assign w_busy = |w_burst;
   assign w_beat = w_burst & cli_valid & {N{bus_ready}};

   // Only a requesting channel can take the bus, and only while
   // nobody holds it; lowest index wins a malformed grant.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      w_accept  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (arb_gnt[i] && w_req[i] && !w_burst[i]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = IW'(i);
         end
      end
      if (w_gnt_any && !w_busy) w_accept[w_gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) r_owner <= '0;
      else if (w_gnt_any && !w_busy) r_owner <= w_gnt_idx;
   end

   for (genvar i = 0; i < N; i++) begin : g_ch
      rr_req_chan #(.LENW(LENW)) u_ch (
         .clk      (clk),
         .rst      (rst),
         .i_valid  (cli_valid[i]),
         .i_accept (w_accept[i]),
         .i_beat   (w_beat[i]),
         .i_len    (cli_len[i*LENW +: LENW]),
         .o_req    (w_req[i]),
         .o_burst  (w_burst[i]),
         .o_last   (w_last[i])
      );
   end

   assign busy      = w_busy;
   assign arb_req   = w_req;
   assign cli_ready = w_burst & {N{bus_ready}};
   assign bus_valid = w_busy & cli_valid[r_owner];
   assign bus_data  = w_busy ? cli_data[r_owner*W +: W] : '0;
   assign bus_id    = w_busy ? r_owner : '0;
   assign bus_last  = w_busy & w_last[r_owner];

`ifdef GNT_CHECK_EN
   logic r_gnt_err;
   logic w_gnt_bad;

   assign w_gnt_bad = !onehot0(16'(arb_gnt)) || (|(arb_gnt & ~w_req));

   always_ff @(posedge clk) begin
      if (rst) r_gnt_err <= 1'b0;
      else if (w_gnt_bad) r_gnt_err <= 1'b1;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst && w_gnt_bad) $error("rr_req_master: bad arb_gnt %b", arb_gnt);
   end
`endif

   assign gnt_err = r_gnt_err;
`endif

endmodule

// File: tb/tb_rr_req_master.sv
// tb_rr_req_master: directed scenarios plus random traffic checked
// every cycle against a request-mask/owner model of the requester.
module tb_rr_req_master;

   localparam int N    = 4;
   localparam int W    = 32;
   localparam int LENW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      cli_valid;
   logic [N*W-1:0]    cli_data;
   logic [N*LENW-1:0] cli_len;
   logic [N-1:0]      cli_ready;
   logic [N-1:0]      arb_req;
   logic [N-1:0]      arb_gnt;
   logic              bus_valid;
   logic [W-1:0]      bus_data;
   logic [1:0]        bus_id;
   logic              bus_last;
   logic              bus_ready;
   logic              busy;
`ifdef GNT_CHECK_EN
   logic              gnt_err;
`endif

   always #5 clk = ~clk;

   rr_req_master #(.N(N), .W(W), .LENW(LENW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cli_valid (cli_valid),
      .cli_data  (cli_data),
      .cli_len   (cli_len),
      .cli_ready (cli_ready),
      .arb_req   (arb_req),
      .arb_gnt   (arb_gnt),
      .bus_valid (bus_valid),
      .bus_data  (bus_data),
      .bus_id    (bus_id),
      .bus_last  (bus_last),
      .bus_ready (bus_ready),
`ifdef GNT_CHECK_EN
      .gnt_err   (gnt_err),
`endif
      .busy      (busy)
   );

   int n_pass = 0;
   int n_tot  = 0;

   // Model: which clients hold a request, who owns the bus, and
   // how many beats after the current one the owner still has.
   bit [N-1:0] m_req;
   int         m_own;
   int         m_rem;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h @%0t", nm, got, exp, $time);
   endtask

   task automatic settle();
      logic [N-1:0] e_rdy;
      logic [W-1:0] e_data;
      logic         e_valid;
      logic         e_last;
      int           e_id;
      #4;
      e_rdy   = '0;
      e_data  = '0;
      e_valid = 1'b0;
      e_last  = 1'b0;
      e_id    = 0;
      if (m_own >= 0) begin
         e_valid      = cli_valid[m_own];
         e_data       = cli_data[m_own*W +: W];
         e_id         = m_own;
         e_last       = (m_rem == 0);
         e_rdy[m_own] = bus_ready;
      end
      chk("arb_req", arb_req, m_req);
      chk("busy", busy, m_own >= 0);
      chk("cli_ready", cli_ready, e_rdy);
      chk("bus_valid", bus_valid, e_valid);
      chk("bus_data", bus_data, e_data);
      chk("bus_id", bus_id, e_id);
      chk("bus_last", bus_last, e_last);
   endtask

   task automatic adv();
      bit [N-1:0] nreq;
      int         nown;
      int         nrem;
      nreq = m_req;
      nown = m_own;
      nrem = m_rem;
      for (int i = 0; i < N; i++)
         if (!m_req[i] && cli_valid[i]) nreq[i] = 1'b1;
      if (m_own >= 0 && cli_valid[m_own] && bus_ready) begin
         if (m_rem == 0) begin
            nreq[m_own] = 1'b0;
            nown = -1;
         end else begin
            nrem = m_rem - 1;
         end
      end
      if (m_own < 0)
         for (int i = 0; i < N; i++)
            if (arb_gnt[i] && m_req[i] && nown < 0) begin
               nown = i;
               nrem = int'(cli_len[i*LENW +: LENW]);
            end
      if (rst) begin
         nreq = '0;
         nown = -1;
         nrem = 0;
      end
      m_req = nreq;
      m_own = nown;
      m_rem = nrem;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      settle();
      adv();
   endtask

   task automatic set_ch(input int c, input bit v, input int len,
                         input logic [W-1:0] d);
      cli_valid[c]            = v;
      cli_len[c*LENW +: LENW] = LENW'(len);
      cli_data[c*W +: W]      = d;
   endtask

   initial begin
      int cand[$];
      int r;
      rst       = 1'b1;
      cli_valid = '0;
      cli_data  = '0;
      cli_len   = '0;
      arb_gnt   = '0;
      bus_ready = 1'b1;
      m_req     = '0;
      m_own     = -1;
      m_rem     = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      settle();
      chk("rst_req", arb_req, 0);
      chk("rst_rdy", cli_ready, 0);
      chk("rst_valid", bus_valid, 0);
      chk("rst_last", bus_last, 0);
      chk("rst_id", bus_id, 0);
      chk("rst_data", bus_data, 0);
      chk("rst_busy", busy, 0);
      adv();

      // single burst, ch1, 4 beats
      set_ch(1, 1, 3, 32'hA0);
      cyc();
      settle();
      chk("t1_req", arb_req, 4'b0010);
      adv();
      arb_gnt = 4'b0010;
      settle();
      chk("t1_busy0", busy, 0);
      adv();
      arb_gnt = '0;
      for (int b = 0; b < 4; b++) begin
         cli_data[1*W +: W] = 32'hA0 + b;
         settle();
         chk("t1_id", bus_id, 1);
         chk("t1_last", bus_last, b == 3);
         chk("t1_lock", arb_req, 4'b0010);
         chk("t1_data", bus_data, 32'hA0 + b);
         adv();
      end
      cli_valid[1] = 1'b0;
      settle();
      chk("t1_release", arb_req, 4'b0000);
      adv();

      // contention, ch0 then ch2
      set_ch(0, 1, 0, 32'hB0);
      set_ch(2, 1, 0, 32'hC2);
      cyc();
      arb_gnt = 4'b0001;
      settle();
      chk("t2_req", arb_req, 4'b0101);
      adv();
      arb_gnt = '0;
      settle();
      chk("t2_id0", bus_id, 0);
      chk("t2_last0", bus_last, 1);
      chk("t2_hold2", arb_req, 4'b0101);
      adv();
      cli_valid[0] = 1'b0;
      arb_gnt      = 4'b0100;
      settle();
      chk("t2_req2", arb_req, 4'b0100);
      adv();
      arb_gnt = '0;
      settle();
      chk("t2_id2", bus_id, 2);
      chk("t2_data2", bus_data, 32'hC2);
      adv();
      cli_valid[2] = 1'b0;
      cyc();

      // backpressure, 2 beats, stall 3 cycles
      set_ch(1, 1, 1, 32'hD0);
      cyc();
      arb_gnt = 4'b0010;
      cyc();
      arb_gnt = '0;
      settle();
      chk("t3_last_b1", bus_last, 0);
      adv();
      cli_data[1*W +: W] = 32'hD1;
      bus_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         settle();
         chk("t3_hold", bus_data, 32'hD1);
         chk("t3_rdy", cli_ready, 0);
         adv();
      end
      bus_ready = 1'b1;
      settle();
      chk("t3_last_b2", bus_last, 1);
      adv();
      cli_valid[1] = 1'b0;
      settle();
      chk("t3_done", busy, 0);
      adv();

      // grant to ch3 while ch0 owns the bus
      set_ch(0, 1, 2, 32'hE0);
      cyc();
      arb_gnt = 4'b0001;
      cyc();
      set_ch(3, 1, 0, 32'hF3);
      arb_gnt = '0;
      cyc();
      arb_gnt = 4'b1000;
      settle();
      chk("t4_own", bus_id, 0);
      adv();
      arb_gnt = '0;
      settle();
      chk("t4_still0", bus_id, 0);
      chk("t4_req", arb_req, 4'b1001);
      adv();
      cli_valid[0] = 1'b0;
      settle();
      chk("t4_wait3", arb_req, 4'b1000);
      chk("t4_idle", busy, 0);
      adv();
      arb_gnt = 4'b1000;
      cyc();
      arb_gnt = '0;
      settle();
      chk("t4_id3", bus_id, 3);
      adv();
      cli_valid[3] = 1'b0;
      cyc();

      // reset during beat 2 of 4
      set_ch(2, 1, 3, 32'h12);
      cyc();
      arb_gnt = 4'b0100;
      cyc();
      arb_gnt = '0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cli_valid[2] = 1'b0;
      settle();
      chk("t5_req", arb_req, 0);
      chk("t5_valid", bus_valid, 0);
      chk("t5_last", bus_last, 0);
      chk("t5_busy", busy, 0);
      adv();
      set_ch(2, 1, 0, 32'h22);
      cyc();
      arb_gnt = 4'b0100;
      cyc();
      arb_gnt = '0;
      settle();
      chk("t5_restart", bus_last, 1);
      adv();
      cli_valid[2] = 1'b0;
      cyc();

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < N; i++) begin
            cli_valid[i]            = ($urandom_range(0, 9) < 7);
            cli_data[i*W +: W]      = $urandom;
            cli_len[i*LENW +: LENW] = LENW'($urandom_range(0, (k % 2) ? 15 : 3));
         end
         bus_ready = ($urandom_range(0, 3) != 0);
         arb_gnt   = '0;
         r         = $urandom_range(0, 9);
         cand.delete();
         for (int i = 0; i < N; i++)
            if (m_req[i] && i != m_own) cand.push_back(i);
         if (r < 4 && cand.size() > 0)
            arb_gnt[cand[$urandom_range(0, cand.size() - 1)]] = 1'b1;
`ifndef GNT_CHECK_EN
         else if (r == 4)
            arb_gnt[$urandom_range(0, N - 1)] = 1'b1;
`endif
         cyc();
      end

`ifdef GNT_CHECK_EN
      rst       = 1'b1;
      cli_valid = '0;
      arb_gnt   = '0;
      cyc();
      rst = 1'b0;
      settle();
      chk("ge_clr", gnt_err, 0);
      adv();
      arb_gnt = 4'b0011;
      cyc();
      arb_gnt = '0;
      repeat (3) begin
         settle();
         chk("ge_sticky", gnt_err, 1);
         adv();
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      settle();
      chk("ge_rst", gnt_err, 0);
      adv();
      arb_gnt = 4'b1000;
      cyc();
      arb_gnt = '0;
      settle();
      chk("ge_noreq", gnt_err, 1);
      adv();
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
